// File: rtl/alu_result_stage.sv
// alu_result_stage: register stage behind the ALU.
// Holds the architectural flags register, evaluates the op's condition code
// against the effective flags at accept time, and buffers {result, cond_true}
// in a two-entry FIFO with valid/ready on both sides.
module alu_result_stage #(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] in_result,
   input  logic [3:0]            in_flags,
   input  logic                  in_flags_we,
   input  logic [3:0]            in_cond,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_result,
   output logic                  out_cond_true,
   output logic [3:0]            flags_q,
   output logic [1:0]            count
);

   // Occupancy at which the buffer refuses new input.
   localparam logic [1:0] FULL_COUNT = DEPTH[1:0];

   logic [1:0]            count_reg;
   logic [3:0]            flags_reg;
   logic [WORD_WIDTH-1:0] head_result_reg;
   logic                  head_cond_reg;
   logic [WORD_WIDTH-1:0] tail_result_reg;
   logic                  tail_cond_reg;

   logic [3:0] eff_flags;
   logic       cond_next;
   logic       accept;
   logic       pop;

   // Flags are [3]=N, [2]=V, [1]=Z, [0]=C.
   function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
      logic n, v, z, c;
      n = f[3];
      v = f[2];
      z = f[1];
      c = f[0];
      case (cc)
         4'd0:    cond_eval = 1'b1;
         4'd1:    cond_eval = z;
         4'd2:    cond_eval = !z;
         4'd3:    cond_eval = !c;
         4'd4:    cond_eval = !c || z;
         4'd5:    cond_eval = c && !z;
         4'd6:    cond_eval = c;
         4'd7:    cond_eval = n ^ v;
         4'd8:    cond_eval = (n ^ v) || z;
         4'd9:    cond_eval = !(n ^ v) && !z;
         4'd10:   cond_eval = !(n ^ v);
         4'd11:   cond_eval = n;
         4'd12:   cond_eval = !n;
         4'd13:   cond_eval = v;
         4'd14:   cond_eval = !v;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   // Handshake and condition evaluation; in_ready depends only on registered state and rst/flush.
   always_comb begin
      in_ready  = !rst && !flush && (count_reg < FULL_COUNT);
      out_valid = (count_reg != 2'd0);
      accept    = in_valid && in_ready;
      pop       = out_valid && out_ready;
      eff_flags = in_flags_we ? in_flags : flags_reg;
      cond_next = cond_eval(in_cond, eff_flags);
   end

   // FIFO occupancy, entry data and architectural flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg       <= 2'd0;
         flags_reg       <= 4'b0000;
         head_result_reg <= '0;
         head_cond_reg   <= 1'b0;
         tail_result_reg <= '0;
         tail_cond_reg   <= 1'b0;
      end else if (flush) begin
         // Buffered entries are dropped; flags from earlier accepted ops survive.
         count_reg <= 2'd0;
      end else begin
         if (accept && in_flags_we) begin
            flags_reg <= in_flags;
         end
         case (count_reg)
            2'd0: begin
               if (accept) begin
                  head_result_reg <= in_result;
                  head_cond_reg   <= cond_next;
                  count_reg       <= 2'd1;
               end
            end
            2'd1: begin
               if (accept && pop) begin
                  head_result_reg <= in_result;
                  head_cond_reg   <= cond_next;
               end else if (accept) begin
                  tail_result_reg <= in_result;
                  tail_cond_reg   <= cond_next;
                  count_reg       <= 2'd2;
               end else if (pop) begin
                  count_reg <= 2'd0;
               end
            end
            2'd2: begin
               // No accept is possible when full; a pop promotes the tail.
               if (pop) begin
                  head_result_reg <= tail_result_reg;
                  head_cond_reg   <= tail_cond_reg;
                  count_reg       <= 2'd1;
               end
            end
            default: count_reg <= 2'd0;
         endcase
      end
   end

   assign out_result    = head_result_reg;
   assign out_cond_true = head_cond_reg;
   assign flags_q       = flags_reg;
   assign count         = count_reg;

endmodule
